// File: rtl/ram_port_arb_if.sv
// ram_port_arb_if: one client's request/grant/read-return bundle for ram_port_arb
//   req    client -> arb  request; held with we/addr/wdata until gnt
//   we     client -> arb  1 = write, 0 = read
//   addr   client -> arb  word address (AW bits)
//   wdata  client -> arb  write data (DW bits)
//   gnt    arb -> client  one-cycle accept pulse
//   rvalid arb -> client  one-cycle read-data-valid pulse
//   rdata  arb -> client  read data, valid while rvalid=1
interface ram_port_arb_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_port_arb.sv
// ram_port_arb: two-client round-robin sequencer for a single-port RAM with RD_LAT read latency
//   sys_clk, sys_rst  clock (rising edge), asynchronous active-high reset
//   a, b              client ports (ram_port_arb_if.slave); a = fill/write, b = display read-back
//   ram_addr/ram_data registered RAM address / write data
//   ram_wren/ram_rden one-cycle RAM command pulses
//   ram_q             RAM read data, valid RD_LAT cycles after ram_rden
//   busy              a read is somewhere in the return pipeline
// Build option: define RAM_ARB_FIXED_PRIO_EN to make client a always win contention.
module ram_port_arb #(
    parameter int RD_LAT = 2,
    parameter int AW     = 8,
    parameter int DW     = 8
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    ram_port_arb_if.slave a,
    ram_port_arb_if.slave b,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_wren,
    output logic          ram_rden,
    input  logic [DW-1:0] ram_q,
    output logic          busy
);
    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    logic              a_gnt_q, b_gnt_q, a_rv_q, b_rv_q;
    logic [DW-1:0]     a_hold, b_hold;
    logic [RD_LAT-1:0] pipe_v, pipe_o;
    logic              a_elig, b_elig, win_a, win_b, win_any, win_we;
    logic [AW-1:0]     win_addr;
    logic [DW-1:0]     win_wdata;

    // a client being granted this cycle still shows its old req; skip it
    assign a_elig = a.req & ~a_gnt_q;
    assign b_elig = b.req & ~b_gnt_q;

`ifdef RAM_ARB_FIXED_PRIO_EN
    assign win_a = a_elig;
`else
    logic last_b;

    assign win_a = a_elig & (~b_elig | last_b);

    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst)
            last_b <= 1'b1;
        else if (win_a | win_b)
            last_b <= win_b;
`endif

    assign win_b     = b_elig & ~win_a;
    assign win_any   = win_a | win_b;
    assign win_we    = win_a ? a.we    : b.we;
    assign win_addr  = win_a ? a.addr  : b.addr;
    assign win_wdata = win_a ? a.wdata : b.wdata;

    // pipe stage 0 is loaded together with ram_rden; rvalid is registered off the
    // last stage so it lands RD_LAT cycles after the command cycle
    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) begin
            a_gnt_q  <= 1'b0;
            b_gnt_q  <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
            ram_wren <= 1'b0;
            ram_rden <= 1'b0;
            pipe_v   <= '0;
            pipe_o   <= '0;
            a_rv_q   <= 1'b0;
            b_rv_q   <= 1'b0;
            a_hold   <= '0;
            b_hold   <= '0;
        end else begin
            a_gnt_q  <= win_a;
            b_gnt_q  <= win_b;
            ram_wren <= win_any & win_we;
            ram_rden <= win_any & ~win_we;
            if (win_any) begin
                ram_addr <= win_addr;
                ram_data <= win_wdata;
            end
            pipe_v[0] <= win_any & ~win_we;
            pipe_o[0] <= win_b ? OWN_B : OWN_A;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_o[i] <= pipe_o[i-1];
            end
            a_rv_q <= pipe_v[RD_LAT-1] & (pipe_o[RD_LAT-1] == OWN_A);
            b_rv_q <= pipe_v[RD_LAT-1] & (pipe_o[RD_LAT-1] == OWN_B);
            if (a_rv_q)
                a_hold <= ram_q;
            if (b_rv_q)
                b_hold <= ram_q;
        end

    // rdata follows ram_q in the rvalid cycle, otherwise holds the last returned word
    assign a.gnt    = a_gnt_q;
    assign b.gnt    = b_gnt_q;
    assign a.rvalid = a_rv_q;
    assign b.rvalid = b_rv_q;
    assign a.rdata  = a_rv_q ? ram_q : a_hold;
    assign b.rdata  = b_rv_q ? ram_q : b_hold;
    assign busy     = |pipe_v;
endmodule

// File: tb/tb_ram_port_arb.sv
// tb_ram_port_arb: directed self-checking bench for ram_port_arb with a 2-cycle RAM model
module tb_ram_port_arb;
    localparam int AW = 8, DW = 8, RD_LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          ram_wren, ram_rden, busy;
    logic [DW-1:0] ram_q = '0;
    logic [AW-1:0] ra = '0;
    logic [DW-1:0] mem [256] = '{default: '0};
    int            n_run = 0, n_fail = 0;

    ram_port_arb_if #(.AW(AW), .DW(DW)) ai ();
    ram_port_arb_if #(.AW(AW), .DW(DW)) bi ();

    ram_port_arb #(.RD_LAT(RD_LAT), .AW(AW), .DW(DW)) dut (
        .sys_clk  (clk),
        .sys_rst  (rst),
        .a        (ai),
        .b        (bi),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_wren (ram_wren),
        .ram_rden (ram_rden),
        .ram_q    (ram_q),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // input-registered, output-registered RAM: q valid two cycles after rden
    always @(posedge clk) begin
        if (ram_wren)
            mem[ram_addr] <= ram_data;
        if (ram_rden)
            ra <= ram_addr;
        ram_q <= mem[ra];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {ram_addr, ram_data, ram_wren, ram_rden, busy, ai.gnt, bi.gnt,
                  ai.rvalid, bi.rvalid, ai.rdata, bi.rdata}, 64'd0);
    endtask

    task automatic wait_gnt(input bit is_b, input string tag);
        int k;
        for (k = 0; k < 10; k++) begin
            step();
            if (is_b ? bi.gnt : ai.gnt)
                break;
        end
        chk(tag, 64'(k < 10), 64'd1);
    endtask

    task automatic a_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        ai.req = 1'b1; ai.we = 1'b1; ai.addr = addr; ai.wdata = data;
        wait_gnt(1'b0, "a_wr_gnt");
        chk("a_wr_cmd", {ram_wren, ram_rden, ram_addr, ram_data}, {1'b1, 1'b0, addr, data});
        ai.req = 1'b0;
    endtask

    initial begin
        logic seen;
        ai.req = 1'b0; ai.we = 1'b0; ai.addr = '0; ai.wdata = '0;
        bi.req = 1'b0; bi.we = 1'b0; bi.addr = '0; bi.wdata = '0;
        repeat (2) step();
        chk_idle("reset_outs");
        rst = 1'b0;
        step();

        // write then back-to-back read of same address by the other client
        a_write(8'h10, 8'h05);
        bi.req = 1'b1; bi.we = 1'b0; bi.addr = 8'h10;
        wait_gnt(1'b1, "b_rd_gnt");
        chk("b_rd_cmd", {ram_rden, ram_wren, ram_addr}, {1'b1, 1'b0, 8'h10});
        bi.req = 1'b0;
        step();
        chk("b_rv_early", {bi.rvalid, ai.rvalid, busy}, 3'b001);
        step();
        chk("b_rv_data", {bi.rvalid, ai.rvalid, bi.rdata}, {1'b1, 1'b0, 8'h05});
        step();
        chk("b_rv_done", {bi.rvalid, ai.rvalid, busy, bi.rdata}, {3'b000, 8'h05});

        // preload, then both clients read continuously
        a_write(8'h20, 8'h11);
        a_write(8'h21, 8'h22);
        ai.req = 1'b1; ai.we = 1'b0; ai.addr = 8'h20;
        bi.req = 1'b1; bi.we = 1'b0; bi.addr = 8'h21;
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("alt_gnt%0d", k), {ai.gnt, bi.gnt}, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k >= 2) begin
                if (k % 2 == 0)
                    chk($sformatf("alt_rv%0d", k), {ai.rvalid, bi.rvalid, bi.rdata}, {2'b01, 8'h22});
                else
                    chk($sformatf("alt_rv%0d", k), {ai.rvalid, bi.rvalid, ai.rdata}, {2'b10, 8'h11});
            end
        end
        ai.req = 1'b0; bi.req = 1'b0;
        repeat (4) step();
        chk("drain_busy", {busy, ai.rvalid, bi.rvalid}, 3'b000);

        // single client held: grant every other cycle, one write pulse per grant
        ai.req = 1'b1; ai.we = 1'b1; ai.addr = 8'h40; ai.wdata = 8'h77;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("hold_gnt%0d", k), {ai.gnt, ram_wren, ram_rden}, (k % 2 == 0) ? 3'b110 : 3'b000);
        end

        // B joins while A keeps requesting: served within two cycles
        bi.req = 1'b1; bi.we = 1'b0; bi.addr = 8'h40;
        seen = 1'b0;
        for (int j = 0; j < 2 && !seen; j++) begin
            step();
            chk($sformatf("contend_one%0d", j), 64'(ai.gnt & bi.gnt), 64'd0);
            seen = bi.gnt;
        end
        chk("contend_b_gnt", 64'(seen), 64'd1);
        ai.req = 1'b0; bi.req = 1'b0;
        repeat (2) step();
        chk("contend_b_data", {bi.rvalid, bi.rdata}, {1'b1, 8'h77});
        repeat (3) step();

        // read in flight, reset pulsed: nothing returns after release
        bi.req = 1'b1; bi.we = 1'b0; bi.addr = 8'h10;
        wait_gnt(1'b1, "rst_b_gnt");
        bi.req = 1'b0;
        step();
        chk("rst_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk_idle("rst_async_outs");
        step();
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            seen = seen | ai.rvalid | bi.rvalid | busy;
        end
        chk("rst_no_rvalid", 64'(seen), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
